// File: rtl/demux_pkg.sv
// Shared constants and slot-placement helper for the demux packer.
// Slot 0 sits at the MSB end of the packed word.
package demux_pkg;

    localparam int DEF_DATA_W    = 4;
    localparam int DEF_NUM_SLOTS = 8;
    localparam int WORD_W        = DEF_DATA_W * DEF_NUM_SLOTS;
    localparam int SEL_W         = $clog2(DEF_NUM_SLOTS);

    typedef logic [DEF_NUM_SLOTS-1:0] slot_mask_t;

    // Top bit of slot k inside a word of num_slots beats of data_w bits.
    function automatic int slot_msb(input int k, input int data_w, input int num_slots);
        return num_slots * data_w - 1 - k * data_w;
    endfunction

endpackage

// File: rtl/demux_out_stage.sv
// One-deep registered valid/ready holding stage for the packed word and its slot mask.
// A load while the held word drains replaces it in the same edge, so there is no bubble.
module demux_out_stage #(
    parameter int WORD_W    = 32,
    parameter int NUM_SLOTS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [WORD_W-1:0]    ld_data,
    input  logic [NUM_SLOTS-1:0] ld_mask,
    input  logic                 ready,
    output logic                 valid,
    output logic [WORD_W-1:0]    data,
    output logic [NUM_SLOTS-1:0] mask,
    output logic                 free
);

    assign free = !valid || ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
            mask  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= ld_data;
            mask  <= ld_mask;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_packer.sv
// Packs DATA_W-bit beats into a NUM_SLOTS-slot word, by auto-increment or explicit slot select,
// and hands the word plus a written-slot mask to a registered output stage.
module demux_packer #(
    parameter int DATA_W    = 4,
    parameter int NUM_SLOTS = 8,
    parameter int AUTO_MODE = 1
) (
    input  logic                           inClk,
    input  logic                           inResetn,
    input  logic                           inValid,
    output logic                           inReady,
    input  logic [DATA_W-1:0]              inData,
    input  logic [$clog2(NUM_SLOTS)-1:0]   inSel,
    input  logic                           inLast,
    output logic                           outValid,
    input  logic                           outReady,
    output logic [DATA_W*NUM_SLOTS-1:0]    outData,
    output logic [NUM_SLOTS-1:0]           outMask,
    output logic                           outErr
);

    localparam int WORD_W = DATA_W * NUM_SLOTS;
    localparam int SEL_W  = $clog2(NUM_SLOTS);

    import demux_pkg::*;

    logic [WORD_W-1:0]    buf_q, nxt_buf;
    logic [NUM_SLOTS-1:0] mask_q, nxt_mask;
    logic [SEL_W-1:0]     cnt_q, idx;
    logic                 pending_q, err_q;
    logic                 accept, sel_bad, wr, complete, out_free, load;

    assign inReady  = !pending_q;
    assign accept   = inValid && inReady;
    assign idx      = (AUTO_MODE != 0) ? cnt_q : inSel;
    assign sel_bad  = (AUTO_MODE == 0) && ({1'b0, inSel} >= (SEL_W+1)'(NUM_SLOTS));
    assign wr       = accept && !sel_bad;
    assign outErr   = err_q;

    // Buffer/mask as they stand after this cycle's write; also what gets loaded on completion.
    for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_slot
        localparam int MSB = slot_msb(k, DATA_W, NUM_SLOTS);
        logic hit;
        assign hit                      = wr && (idx == SEL_W'(k));
        assign nxt_buf[MSB -: DATA_W]   = hit ? inData : buf_q[MSB -: DATA_W];
        assign nxt_mask[NUM_SLOTS-1-k]  = mask_q[NUM_SLOTS-1-k] | hit;
    end

    assign complete = accept && (inLast || (&nxt_mask));
    assign load     = out_free && (complete || pending_q);

    always_ff @(posedge inClk or negedge inResetn) begin
        if (!inResetn) begin
            buf_q     <= '0;
            mask_q    <= '0;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            err_q <= accept && sel_bad;
            if (accept)
                cnt_q <= complete ? '0 : cnt_q + 1'b1;
            if (load) begin
                buf_q     <= '0;
                mask_q    <= '0;
                pending_q <= 1'b0;
            end else if (accept) begin
                // A completing beat that cannot leave yet parks the word and stalls input.
                buf_q     <= nxt_buf;
                mask_q    <= nxt_mask;
                pending_q <= complete;
            end
        end
    end

    demux_out_stage #(
        .WORD_W    (WORD_W),
        .NUM_SLOTS (NUM_SLOTS)
    ) u_out (
        .clk     (inClk),
        .rst_n   (inResetn),
        .load    (load),
        .ld_data (nxt_buf),
        .ld_mask (nxt_mask),
        .ready   (outReady),
        .valid   (outValid),
        .data    (outData),
        .mask    (outMask),
        .free    (out_free)
    );

endmodule

// File: tb/tb_demux_packer.sv
// Scoreboard bench: three packer configurations (auto/8, explicit/8, explicit/6) share clock and reset.
module tb_demux_packer;

    logic inClk = 1'b0;
    logic inResetn = 1'b0;
    always #5 inClk = ~inClk;

    int checks = 0;
    int errors = 0;

    // auto mode, 8 slots
    logic a_valid = 0, a_last = 0, a_oready = 0;
    logic [3:0] a_data = '0;
    logic [2:0] a_sel = '0;
    logic a_ready, a_ovalid, a_oerr;
    logic [31:0] a_odata;
    logic [7:0] a_omask;
    // explicit mode, 8 slots
    logic e_valid = 0, e_last = 0, e_oready = 0;
    logic [3:0] e_data = '0;
    logic [2:0] e_sel = '0;
    logic e_ready, e_ovalid, e_oerr;
    logic [31:0] e_odata;
    logic [7:0] e_omask;
    // explicit mode, 6 slots
    logic s_valid = 0, s_last = 0, s_oready = 0;
    logic [3:0] s_data = '0;
    logic [2:0] s_sel = '0;
    logic s_ready, s_ovalid, s_oerr;
    logic [23:0] s_odata;
    logic [5:0] s_omask;

    logic [39:0] qa[$];
    logic [39:0] qe[$];
    logic [29:0] qs[$];

    demux_packer #(.DATA_W(4), .NUM_SLOTS(8), .AUTO_MODE(1)) u_auto (
        .inClk(inClk), .inResetn(inResetn), .inValid(a_valid), .inReady(a_ready),
        .inData(a_data), .inSel(a_sel), .inLast(a_last), .outValid(a_ovalid),
        .outReady(a_oready), .outData(a_odata), .outMask(a_omask), .outErr(a_oerr));

    demux_packer #(.DATA_W(4), .NUM_SLOTS(8), .AUTO_MODE(0)) u_expl (
        .inClk(inClk), .inResetn(inResetn), .inValid(e_valid), .inReady(e_ready),
        .inData(e_data), .inSel(e_sel), .inLast(e_last), .outValid(e_ovalid),
        .outReady(e_oready), .outData(e_odata), .outMask(e_omask), .outErr(e_oerr));

    demux_packer #(.DATA_W(4), .NUM_SLOTS(6), .AUTO_MODE(0)) u_six (
        .inClk(inClk), .inResetn(inResetn), .inValid(s_valid), .inReady(s_ready),
        .inData(s_data), .inSel(s_sel), .inLast(s_last), .outValid(s_ovalid),
        .outReady(s_oready), .outData(s_odata), .outMask(s_omask), .outErr(s_oerr));

    // Output monitors: a word leaves on the edge after a negedge with valid && ready.
    always @(negedge inClk) begin
        if (inResetn && a_ovalid && a_oready) begin
            logic [39:0] exp;
            checks++;
            if (qa.size() == 0) begin
                errors++;
                $display("FAIL auto_word: unexpected word %h/%h", a_odata, a_omask);
            end else begin
                exp = qa.pop_front();
                if ({a_odata, a_omask} !== exp) begin
                    errors++;
                    $display("FAIL auto_word: got %h/%h want %h/%h", a_odata, a_omask, exp[39:8], exp[7:0]);
                end
            end
        end
        if (inResetn && e_ovalid && e_oready) begin
            logic [39:0] exp;
            checks++;
            if (qe.size() == 0) begin
                errors++;
                $display("FAIL expl_word: unexpected word %h/%h", e_odata, e_omask);
            end else begin
                exp = qe.pop_front();
                if ({e_odata, e_omask} !== exp) begin
                    errors++;
                    $display("FAIL expl_word: got %h/%h want %h/%h", e_odata, e_omask, exp[39:8], exp[7:0]);
                end
            end
        end
        if (inResetn && s_ovalid && s_oready) begin
            logic [29:0] exp;
            checks++;
            if (qs.size() == 0) begin
                errors++;
                $display("FAIL six_word: unexpected word %h/%h", s_odata, s_omask);
            end else begin
                exp = qs.pop_front();
                if ({s_odata, s_omask} !== exp) begin
                    errors++;
                    $display("FAIL six_word: got %h/%h want %h/%h", s_odata, s_omask, exp[29:6], exp[5:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge inClk); #1;
    endtask

    // Each send returns #1 after the edge that accepted the beat.
    task automatic send_a(input logic [3:0] d, input logic last);
        bit acc = 0;
        int n = 0;
        a_valid = 1; a_data = d; a_last = last;
        while (!acc && n < 40) begin
            @(negedge inClk); acc = a_ready;
            @(posedge inClk); #1; n++;
        end
        if (!acc) begin
            checks++; errors++;
            $display("FAIL auto_send_timeout: ready=%b want 1", a_ready);
        end
        a_valid = 0; a_last = 0;
    endtask

    task automatic send_e(input logic [3:0] d, input logic [2:0] sel, input logic last);
        bit acc = 0;
        int n = 0;
        e_valid = 1; e_data = d; e_sel = sel; e_last = last;
        while (!acc && n < 40) begin
            @(negedge inClk); acc = e_ready;
            @(posedge inClk); #1; n++;
        end
        if (!acc) begin
            checks++; errors++;
            $display("FAIL expl_send_timeout: ready=%b want 1", e_ready);
        end
        e_valid = 0; e_last = 0;
    endtask

    task automatic send_s(input logic [3:0] d, input logic [2:0] sel, input logic last);
        bit acc = 0;
        int n = 0;
        s_valid = 1; s_data = d; s_sel = sel; s_last = last;
        while (!acc && n < 40) begin
            @(negedge inClk); acc = s_ready;
            @(posedge inClk); #1; n++;
        end
        if (!acc) begin
            checks++; errors++;
            $display("FAIL six_send_timeout: ready=%b want 1", s_ready);
        end
        s_valid = 0; s_last = 0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge inClk);
        #1;
        checks++;
        if ({a_ovalid, a_odata, a_omask, a_oerr, a_ready} !== {1'b0, 32'h0, 8'h0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_state: v=%b d=%h m=%h e=%b r=%b want 0/0/0/0/1",
                     a_ovalid, a_odata, a_omask, a_oerr, a_ready);
        end
        inResetn = 1;
        tick();
    endtask

    task automatic test_auto_full();
        a_oready = 1;
        qa.push_back({32'h12345678, 8'hFF});
        for (int i = 1; i <= 8; i++) send_a(4'(i), 1'b0);
        checks++;
        if (a_ovalid !== 1'b1) begin
            errors++;
            $display("FAIL auto_full_latency: outValid=%b want 1", a_ovalid);
        end
        tick(); tick();
    endtask

    task automatic test_auto_last();
        qa.push_back({32'hABC00000, 8'hE0});
        send_a(4'hA, 0); send_a(4'hB, 0); send_a(4'hC, 1);
        qa.push_back({32'h10000000, 8'h80});
        send_a(4'h1, 1);
        tick(); tick();
    endtask

    task automatic test_explicit();
        e_oready = 1;
        qe.push_back({32'h90020005, 8'h91});
        send_e(4'h5, 3'd7, 0); send_e(4'h9, 3'd0, 0); send_e(4'h2, 3'd3, 1);
        qe.push_back({32'h900E0005, 8'h91});
        send_e(4'h5, 3'd7, 0); send_e(4'h9, 3'd0, 0); send_e(4'h2, 3'd3, 0); send_e(4'hE, 3'd3, 1);
        tick(); tick();
    endtask

    task automatic test_backpressure();
        a_oready = 0;
        qa.push_back({32'h12345678, 8'hFF});
        for (int i = 1; i <= 8; i++) send_a(4'(i), 1'b0);
        qa.push_back({32'h87654321, 8'hFF});
        for (int i = 8; i >= 1; i--) send_a(4'(i), 1'b0);
        checks++;
        if (a_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_ready_low: inReady=%b want 0", a_ready);
        end
        tick(); tick(); tick();
        checks++;
        if ({a_ovalid, a_odata, a_ready} !== {1'b1, 32'h12345678, 1'b0}) begin
            errors++;
            $display("FAIL bp_hold: v=%b d=%h r=%b want 1/12345678/0", a_ovalid, a_odata, a_ready);
        end
        a_oready = 1;
        tick();
        checks++;
        if ({a_ovalid, a_odata, a_ready} !== {1'b1, 32'h87654321, 1'b1}) begin
            errors++;
            $display("FAIL bp_reload: v=%b d=%h r=%b want 1/87654321/1", a_ovalid, a_odata, a_ready);
        end
        tick(); tick();
    endtask

    task automatic test_back_to_back();
        a_oready = 0;
        qa.push_back({32'hFEDCBA98, 8'hFF});
        for (int i = 15; i >= 8; i--) send_a(4'(i), 1'b0);
        for (int i = 0; i < 7; i++) send_a(4'(i), 1'b0);
        qa.push_back({32'h01234567, 8'hFF});
        a_oready = 1;
        send_a(4'h7, 1'b0);
        checks++;
        if ({a_ovalid, a_odata, a_ready} !== {1'b1, 32'h01234567, 1'b1}) begin
            errors++;
            $display("FAIL b2b_no_bubble: v=%b d=%h r=%b want 1/01234567/1", a_ovalid, a_odata, a_ready);
        end
        tick(); tick();
    endtask

    task automatic test_sel_error();
        s_oready = 1;
        qs.push_back({24'h340000, 6'h30});
        send_s(4'h3, 3'd0, 0);
        send_s(4'hF, 3'd7, 0);
        checks++;
        if (s_oerr !== 1'b1) begin
            errors++;
            $display("FAIL err_pulse: outErr=%b want 1", s_oerr);
        end
        tick();
        checks++;
        if (s_oerr !== 1'b0) begin
            errors++;
            $display("FAIL err_one_cycle: outErr=%b want 0", s_oerr);
        end
        send_s(4'h4, 3'd1, 1);
        qs.push_back({24'h007000, 6'h08});
        send_s(4'h7, 3'd2, 0);
        send_s(4'h1, 3'd6, 1);
        tick(); tick();
    endtask

    task automatic test_reset_mid_frame();
        a_oready = 0;
        for (int i = 1; i <= 8; i++) send_a(4'(i), 1'b0);
        send_a(4'h1, 0); send_a(4'h2, 0); send_a(4'h3, 0);
        inResetn = 0;
        #1;
        checks++;
        if ({a_ovalid, a_odata, a_omask, a_oerr, a_ready} !== {1'b0, 32'h0, 8'h0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL mid_reset: v=%b d=%h m=%h e=%b r=%b want 0/0/0/0/1",
                     a_ovalid, a_odata, a_omask, a_oerr, a_ready);
        end
        tick(); tick();
        inResetn = 1;
        tick();
        a_oready = 1;
        qa.push_back({32'h50000000, 8'h80});
        send_a(4'h5, 1);
        tick(); tick();
    endtask

    initial begin
        test_reset();
        test_auto_full();
        test_auto_last();
        test_explicit();
        test_backpressure();
        test_back_to_back();
        test_sel_error();
        test_reset_mid_frame();
        repeat (3) tick();
        checks++;
        if (qa.size() + qe.size() + qs.size() != 0) begin
            errors++;
            $display("FAIL words_missing: left %0d/%0d/%0d want 0/0/0", qa.size(), qe.size(), qs.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
